// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the keyboard receiver FIFO,
// strips E0/F0 prefixes and emits make/repeat/break events with held-key state.
module ps2_scan_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       data,
   input  logic             ready,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             fifo_clr_n,
   output logic             key_valid,
   output logic             key_break,
   output logic             key_repeat,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_pressed,
   output logic [7:0]       ascii,
   output logic [CNT_W-1:0] press_count
);

   typedef enum logic [1:0] {H_IDLE, H_POP, H_WAIT} h_state_t;
   typedef enum logic [1:0] {D_BASE, D_EXT, D_BRK, D_EXTBRK} d_state_t;

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   h_state_t h_state_reg, h_state_next;
   d_state_t d_state_reg, d_state_next;

   logic accept;
   logic ev_make;
   logic ev_break;
   logic ev_ext;
   logic held_match;

   function automatic logic [7:0] ascii_of(input logic [7:0] code);
      logic [7:0] a;
      a = 8'h00;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   // Byte acceptance happens on the H_IDLE->H_POP edge, so an event decoded
   // from that byte lands in the registered outputs during the H_POP cycle.
   always_comb begin
      h_state_next = h_state_reg;
      d_state_next = d_state_reg;
      accept       = 1'b0;
      ev_make      = 1'b0;
      ev_break     = 1'b0;
      ev_ext       = 1'b0;

      if (overflow) begin
         h_state_next = H_IDLE;
         d_state_next = D_BASE;
      end else begin
         case (h_state_reg)
            H_IDLE: begin
               if (ready) begin
                  accept       = 1'b1;
                  h_state_next = H_POP;
               end
            end
            H_POP:   h_state_next = H_WAIT;
            H_WAIT:  h_state_next = H_IDLE;
            default: h_state_next = H_IDLE;
         endcase
      end

      if (accept) begin
         case (d_state_reg)
            D_BASE: begin
               if (data == PFX_EXT)      d_state_next = D_EXT;
               else if (data == PFX_BRK) d_state_next = D_BRK;
               else                      ev_make = 1'b1;
            end
            D_EXT: begin
               if (data == PFX_BRK) begin
                  d_state_next = D_EXTBRK;
               end else if (data == PFX_EXT) begin
                  d_state_next = D_EXT;
               end else begin
                  ev_make      = 1'b1;
                  ev_ext       = 1'b1;
                  d_state_next = D_BASE;
               end
            end
            D_BRK: begin
               ev_break     = 1'b1;
               d_state_next = D_BASE;
            end
            D_EXTBRK: begin
               ev_break     = 1'b1;
               ev_ext       = 1'b1;
               d_state_next = D_BASE;
            end
            default: d_state_next = D_BASE;
         endcase
      end
   end

   assign held_match = key_pressed && (data == key_code) && (ev_ext == key_ext);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         h_state_reg <= H_IDLE;
         d_state_reg <= D_BASE;
         nextdata_n  <= 1'b1;
         fifo_clr_n  <= 1'b1;
         key_valid   <= 1'b0;
         key_break   <= 1'b0;
         key_repeat  <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_pressed <= 1'b0;
         ascii       <= 8'h00;
         press_count <= '0;
      end else begin
         h_state_reg <= h_state_next;
         d_state_reg <= d_state_next;
         nextdata_n  <= (h_state_next != H_POP);
         fifo_clr_n  <= ~overflow;
         key_valid   <= 1'b0;
         key_break   <= 1'b0;
         key_repeat  <= 1'b0;

         if (overflow) begin
            // Lost bytes may include a break code, so forget the held key silently.
            key_pressed <= 1'b0;
         end else if (ev_make) begin
            key_valid <= 1'b1;
            ascii     <= ev_ext ? 8'h00 : ascii_of(data);
            if (held_match) begin
               key_repeat <= 1'b1;
            end else begin
               key_code    <= data;
               key_ext     <= ev_ext;
               key_pressed <= 1'b1;
               press_count <= press_count + 1'b1;
            end
         end else if (ev_break) begin
            key_valid <= 1'b1;
            key_break <= 1'b1;
            if (held_match) key_pressed <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sits between the ps2_keyboard receiver FIFO and the display/application logic.
- Pops scan-code bytes from the receiver using the ready/nextdata_n handshake.
- Tracks set-2 prefixes (E0 extended, F0 break) and emits one registered key event per completed code: make, typematic repeat or break.
- Also provides the held-key state, a lowercase ASCII translation and a distinct-press counter for the seven-segment path.

Parameters:
- CNT_W, 8, width of press_count; the counter wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  reset. Asynchronous, active-low.
- data  in  8  head byte of the receiver FIFO; valid while ready=1.
- ready  in  1  receiver FIFO non-empty.
- overflow  in  1  receiver FIFO overflow flag.
- nextdata_n  out  1  active-low pop strobe to the receiver.
- fifo_clr_n  out  1  active-low one-cycle clear request to the receiver (drives its clrn).
- key_valid  out  1  one-cycle event strobe.
- key_break  out  1  qualifies key_valid: 1 means release event.
- key_repeat  out  1  qualifies key_valid: 1 means typematic repeat of the held key.
- key_code  out  8  scan code of the last event (without prefixes).
- key_ext  out  1  last event carried the E0 prefix.
- key_pressed  out  1  level; a key is currently held.
- ascii  out  8  ASCII of the last make/repeat event; 0x00 if the key is unmapped.
- press_count  out  CNT_W  number of new (non-repeat) presses.

Behaviour:
- Reset (clrn=0, asynchronous):
  - nextdata_n=1, fifo_clr_n=1.
  - key_valid, key_break, key_repeat, key_ext and key_pressed = 0.
  - key_code=0x00, ascii=0x00, press_count=0.
  - Handshake FSM to H_IDLE; decode FSM to D_BASE.
  - Reset mid-pop or mid-sequence discards the partial code.
- Handshake FSM (H_IDLE, H_POP, H_WAIT):
  - H_IDLE: when ready=1 and overflow=0, latch data at the edge and go to H_POP.
  - H_POP: nextdata_n=0 for exactly one cycle; go to H_WAIT.
  - H_WAIT: nextdata_n=1 for one cycle so the receiver's ready/data settle; return to H_IDLE.
  - Result: at most one byte per 3 cycles; nextdata_n is never low for two consecutive cycles.
- Overflow has priority over everything else:
  - In any cycle with overflow=1, fifo_clr_n=0 on the next cycle, for exactly one cycle.
  - Handshake returns to H_IDLE; decode returns to D_BASE.
  - key_pressed is cleared, with no event emitted.
  - press_count, key_code and ascii are retained.
  - ready is ignored while overflow=1.
- Decode FSM (D_BASE, D_EXT, D_BRK, D_EXTBRK); transitions occur on each latched byte b:
  - D_BASE: b=E0 goes to D_EXT; b=F0 goes to D_BRK; otherwise it is a make event with ext=0.
  - D_EXT: b=F0 goes to D_EXTBRK; b=E0 stays in D_EXT; otherwise it is a make event with ext=1, then D_BASE.
  - D_BRK / D_EXTBRK: any b is a break event with ext=0 / 1 respectively, then D_BASE.
- Make event:
  - If key_pressed=1 and (b, ext) equals (key_code, key_ext), it is a repeat: key_repeat=1 and press_count is unchanged.
  - Otherwise it is a new press: key_code=b, key_ext=ext, key_pressed=1, press_count+1 (wraps to 0).
  - A new press while another key is held replaces the held key.
- Break event:
  - key_break=1.
  - key_pressed is cleared only if (b, ext) matches the held key; otherwise it is unchanged.
  - key_code and ascii are retained.
- Event timing and qualifiers:
  - key_valid is high for exactly one cycle: the H_POP cycle of the byte that completes the code.
  - key_break and key_repeat are valid only while key_valid=1 and are 0 otherwise.
  - Prefix bytes produce no strobe.
- ASCII table (non-extended make only; extended keys give 0x00):
  - Letters a..z (0x61..0x7A) from scan codes 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Digits 0..9 from 45 16 1E 26 25 2E 36 3D 3E 46.
  - Code 29 gives 0x20 (space); 5A gives 0x0D (enter); all other codes give 0x00.

Test Plan:
- Bytes 1C, F0, 1C → make strobe: code=1C, ascii=0x61, key_pressed=1, press_count=1. Then break strobe: key_break=1, key_pressed=0, press_count=1. Exactly 2 strobes.
- Bytes 1C, 1C, 1C, F0, 1C → 3 make strobes with key_repeat=0,1,1; press_count=1; final key_pressed=0.
- Bytes E0, 75, E0, F0, 75 → make strobe: ext=1, code=75, ascii=0x00, press_count+1. Then break strobe with ext=1 clears key_pressed. Prefix bytes give no strobe.
- Bytes 1C, F0, then overflow=1 for 1 cycle → fifo_clr_n low exactly 1 cycle, key_pressed=0, press_count retained. A following 32 yields a make (ascii=0x62), not a break.
- Handshake: ready held high with 4 queued bytes → nextdata_n low exactly 4 single cycles, at least 2 high cycles between pops. Then clrn pulsed low during H_POP → all outputs return to reset values immediately, without waiting for clk.
- 256 alternating new presses (1C/32, each followed by its break) → press_count reads 255 after the 255th press and 0 after the 256th.
